// File: rtl/ssd_scan_driver_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver:
// glyph constants and the hex-to-segment decode function.
package ssd_scan_driver_pkg;

    localparam int PHASE_BITS = 4;
    localparam int SEG_BITS   = 7;

    // Glyphs are active-high {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bus between the game-state producer and the scan driver: display content
// and brightness in, multiplexed anode/cathode drive and scan status out.
interface ssd_scan_driver_if
    import ssd_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) ();
    localparam int IW = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [PHASE_BITS-1:0]   brightness;
    logic                    load;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [7:0]              cathodes;
    logic [IW-1:0]           scan_idx;
    logic                    frame_tick;

    modport master (
        output digits_in, dp_in, digit_en, blink_en, brightness, load,
        input  anodes, cathodes, scan_idx, frame_tick
    );

    modport slave (
        input  digits_in, dp_in, digit_en, blink_en, brightness, load,
        output anodes, cathodes, scan_idx, frame_tick
    );

endinterface

// File: rtl/ssd_scan_driver_chk.sv
// Structural properties of the scan driver outputs, checked from the pins.
module ssd_scan_driver_chk #(
    parameter int NUM_DIGITS = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic                          clk,
    input logic                          rst,
    input logic [NUM_DIGITS-1:0]         anodes,
    input logic [7:0]                    cathodes,
    input logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    input logic                          frame_tick
);
    localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            CAT_MASK = {8{ACTIVE_LOW}};

    a_anode_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(anodes ^ AN_MASK));

    a_dark_cathodes: assert property (@(posedge clk) disable iff (rst)
        (anodes == AN_MASK) |-> (cathodes == CAT_MASK));

    a_tick_at_zero: assert property (@(posedge clk) disable iff (rst)
        frame_tick |-> (scan_idx == '0));

    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        int'(scan_idx) < NUM_DIGITS);

endmodule

// File: rtl/ssd_scan_driver_hex_decode.sv
// Combinational hex nibble to active-high {a..g} segment pattern.
module ssd_hex_decode
    import ssd_scan_driver_pkg::*;
(
    input  logic [3:0]          hex,
    output logic [SEG_BITS-1:0] seg
);

    // Table lookup kept in the package so other blocks share the same glyphs.
    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered content,
// per-digit blank/blink/dp, PWM brightness and a dead-time guard per slot.
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV_BITS  = 18,
    parameter int BLINK_DIV_BITS = 26,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input logic          clk,
    input logic          rst,
    ssd_scan_driver_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [IW-1:0]             LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0]             IDX_ONE    = IW'(1);
    localparam logic [IW-1:0]             IDX_ZERO   = IW'(0);
    localparam logic [SCAN_DIV_BITS-1:0]  PRESC_ONE  = SCAN_DIV_BITS'(1);
    localparam logic [SCAN_DIV_BITS-1:0]  PRESC_ZERO = SCAN_DIV_BITS'(0);
    localparam logic [BLINK_DIV_BITS-1:0] BLINK_ONE  = BLINK_DIV_BITS'(1);
    localparam logic [BLINK_DIV_BITS-1:0] BLINK_ZERO = BLINK_DIV_BITS'(0);
    localparam logic [NUM_DIGITS-1:0]     AN_ONE     = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0]     AN_NONE    = {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0]     AN_MASK    = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]                CAT_MASK   = {8{ACTIVE_LOW}};

    logic [SCAN_DIV_BITS-1:0]  presc_r;
    logic [IW-1:0]             scan_idx_r;
    logic                      frame_tick_r;
    logic [BLINK_DIV_BITS-1:0] blink_ctr_r;
    logic                      blink_phase_r;

    logic [4*NUM_DIGITS-1:0]   stg_digits_r;
    logic [NUM_DIGITS-1:0]     stg_dp_r;
    logic [NUM_DIGITS-1:0]     stg_en_r;
    logic [NUM_DIGITS-1:0]     stg_blink_r;
    logic                      pending_r;

    logic [4*NUM_DIGITS-1:0]   sh_digits_r;
    logic [NUM_DIGITS-1:0]     sh_dp_r;
    logic [NUM_DIGITS-1:0]     sh_en_r;
    logic [NUM_DIGITS-1:0]     sh_blink_r;

    logic [NUM_DIGITS-1:0]     anodes_r;
    logic [7:0]                cathodes_r;

    logic                      slot_end_s;
    logic                      wrap_s;
    logic [PHASE_BITS-1:0]     phase_s;
    logic [3:0]                cur_hex_s;
    logic [SEG_BITS-1:0]       seg_s;
    logic                      lit_s;
    logic [NUM_DIGITS-1:0]     an_next_s;
    logic [7:0]                cat_next_s;

    assign slot_end_s = &presc_r;
    assign wrap_s     = slot_end_s && (scan_idx_r == LAST_IDX);
    assign phase_s    = presc_r[SCAN_DIV_BITS-1 -: PHASE_BITS];
    assign cur_hex_s  = sh_digits_r[{scan_idx_r, 2'b00} +: 4];

    // Phase 0 is kept dark so the previous digit's glyph never ghosts onto the next anode.
    assign lit_s = sh_en_r[scan_idx_r]
                && !(sh_blink_r[scan_idx_r] && blink_phase_r)
                && (phase_s < bus.brightness)
                && (phase_s != 4'd0);

    ssd_hex_decode u_hex_decode (
        .hex (cur_hex_s),
        .seg (seg_s)
    );

    // Slot prescaler, digit scan counter with explicit wrap, and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r      <= PRESC_ZERO;
            scan_idx_r   <= IDX_ZERO;
            frame_tick_r <= 1'b0;
        end else begin
            presc_r      <= presc_r + PRESC_ONE;
            frame_tick_r <= wrap_s;
            if (wrap_s) begin
                scan_idx_r <= IDX_ZERO;
            end else if (slot_end_s) begin
                scan_idx_r <= scan_idx_r + IDX_ONE;
            end else begin
                scan_idx_r <= scan_idx_r;
            end
        end
    end

    // Free-running blink timebase; phase flips each time the counter rolls over.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_ctr_r   <= BLINK_ZERO;
            blink_phase_r <= 1'b0;
        end else begin
            blink_ctr_r <= blink_ctr_r + BLINK_ONE;
            if (&blink_ctr_r) begin
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_phase_r <= blink_phase_r;
            end
        end
    end

    // Staging captures on load; shadow only changes at a frame wrap, and a load
    // landing on that same edge defers the transfer by one frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_digits_r <= {(4*NUM_DIGITS){1'b0}};
            stg_dp_r     <= AN_NONE;
            stg_en_r     <= AN_NONE;
            stg_blink_r  <= AN_NONE;
            pending_r    <= 1'b0;
            sh_digits_r  <= {(4*NUM_DIGITS){1'b0}};
            sh_dp_r      <= AN_NONE;
            sh_en_r      <= AN_NONE;
            sh_blink_r   <= AN_NONE;
        end else if (bus.load) begin
            stg_digits_r <= bus.digits_in;
            stg_dp_r     <= bus.dp_in;
            stg_en_r     <= bus.digit_en;
            stg_blink_r  <= bus.blink_en;
            pending_r    <= 1'b1;
        end else if (wrap_s && pending_r) begin
            sh_digits_r  <= stg_digits_r;
            sh_dp_r      <= stg_dp_r;
            sh_en_r      <= stg_en_r;
            sh_blink_r   <= stg_blink_r;
            pending_r    <= 1'b0;
        end else begin
            pending_r    <= pending_r;
        end
    end

    // Next pin values in lit-high polarity.
    always_comb begin
        an_next_s  = AN_NONE;
        cat_next_s = 8'h00;
        if (lit_s) begin
            an_next_s  = AN_ONE << scan_idx_r;
            cat_next_s = {seg_s, sh_dp_r[scan_idx_r]};
        end else begin
            an_next_s  = AN_NONE;
            cat_next_s = 8'h00;
        end
    end

    // Pin registers; board polarity is applied here so everything upstream is lit-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            anodes_r   <= AN_MASK;
            cathodes_r <= CAT_MASK;
        end else begin
            anodes_r   <= an_next_s ^ AN_MASK;
            cathodes_r <= cat_next_s ^ CAT_MASK;
        end
    end

    assign bus.anodes     = anodes_r;
    assign bus.cathodes   = cathodes_r;
    assign bus.scan_idx   = scan_idx_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: per-slot records of the 4-digit driver are checked against
// hand-computed expectations; a 3-digit instance checks scan wrap and frame period.
module tb_ssd_scan_driver;

    logic clk;
    logic rst;

    ssd_scan_driver_if #(.NUM_DIGITS(4)) if4 ();
    ssd_scan_driver_if #(.NUM_DIGITS(3)) if3 ();

    ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV_BITS(5), .BLINK_DIV_BITS(8), .ACTIVE_LOW(1'b1))
        dut4 (.clk(clk), .rst(rst), .bus(if4));
    ssd_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV_BITS(5), .BLINK_DIV_BITS(8), .ACTIVE_LOW(1'b1))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    ssd_scan_driver_chk #(.NUM_DIGITS(4), .ACTIVE_LOW(1'b1)) chk4 (
        .clk(clk), .rst(rst), .anodes(if4.anodes), .cathodes(if4.cathodes),
        .scan_idx(if4.scan_idx), .frame_tick(if4.frame_tick));
    ssd_scan_driver_chk #(.NUM_DIGITS(3), .ACTIVE_LOW(1'b1)) chk3 (
        .clk(clk), .rst(rst), .anodes(if3.anodes), .cathodes(if3.cathodes),
        .scan_idx(if3.scan_idx), .frame_tick(if3.frame_tick));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] an;
        logic [7:0] cat;
        logic [7:0] cnt;
        logic       ok;
    } rec_t;

    rec_t exp_q[$];
    int   exp3_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    bit   mon3_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    task automatic push(input logic [1:0] idx, input logic [3:0] an, input logic [7:0] cat,
                        input logic [7:0] cnt);
        exp_q.push_back('{idx: idx, an: an, cat: cat, cnt: cnt, ok: 1'b1});
    endtask

    task automatic push_dark_frame(input int first);
        for (int i = first; i < 4; i++) push(2'(i), 4'hF, 8'hFF, 8'd0);
    endtask

    task automatic load4(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                         input logic [3:0] bl);
        if4.digits_in = d; if4.dp_in = dp; if4.digit_en = en; if4.blink_en = bl;
        if4.load = 1'b1;
        @(posedge clk); #1;
        if4.load = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            if (if4.frame_tick === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL frame_wait: frame_tick not seen within 300 cycles");
    endtask

    // Monitor for the 4-digit instance: one record per scan slot.
    initial begin
        logic [1:0] cur_idx = 2'd0;
        bit         rec_valid = 1'b0;
        int         lit_cnt = 0;
        logic [3:0] an_seen = 4'hF;
        logic [7:0] cat_seen = 8'hFF;
        logic       rec_ok = 1'b1;
        rec_t       got, e;
        forever begin
            @(negedge clk);
            if (if4.scan_idx != cur_idx) begin
                if (rec_valid) begin
                    got = '{idx: cur_idx, an: an_seen, cat: cat_seen, cnt: 8'(lit_cnt), ok: rec_ok};
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL slot_record: unexpected record idx=%0d an=%h cat=%h cnt=%0d",
                                 got.idx, got.an, got.cat, got.cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (got === e) n_pass++;
                        else $display("FAIL slot_record: got idx=%0d an=%h cat=%h lit=%0d ok=%0b, expected idx=%0d an=%h cat=%h lit=%0d ok=%0b",
                                      got.idx, got.an, got.cat, got.cnt, got.ok,
                                      e.idx, e.an, e.cat, e.cnt, e.ok);
                    end
                end
                cur_idx   = if4.scan_idx;
                rec_valid = mon_en;
                lit_cnt   = 0;
                an_seen   = 4'hF;
                cat_seen  = 8'hFF;
                rec_ok    = 1'b1;
            end
            if (rec_valid) begin
                if (if4.anodes != 4'hF) begin
                    if (lit_cnt == 0) begin
                        an_seen  = if4.anodes;
                        cat_seen = if4.cathodes;
                    end else if (if4.anodes != an_seen || if4.cathodes != cat_seen) begin
                        rec_ok = 1'b0;
                    end
                    lit_cnt++;
                end else if (if4.cathodes != 8'hFF) begin
                    rec_ok = 1'b0;
                end
            end
        end
    end

    // Monitor for the 3-digit instance: frame period, scan order, anode selection.
    initial begin
        int         cyc = 0;
        bit         have_tick = 1'b0;
        bit         have_idx = 1'b0;
        logic [1:0] prev_idx = 2'd0;
        logic [1:0] exp_idx;
        logic [2:0] exp_an;
        forever begin
            @(negedge clk);
            if (mon3_en) begin
                if (if3.frame_tick === 1'b1) begin
                    if (have_tick && exp3_q.size() > 0) chk("frame3_period", cyc, exp3_q.pop_front());
                    have_tick = 1'b1;
                    cyc = 1;
                end else begin
                    cyc++;
                end
                if (!have_idx) begin
                    prev_idx = if3.scan_idx;
                    have_idx = 1'b1;
                end else if (if3.scan_idx != prev_idx) begin
                    exp_idx = (prev_idx == 2'd2) ? 2'd0 : prev_idx + 2'd1;
                    chk("scan3_order", 32'(if3.scan_idx), 32'(exp_idx));
                    prev_idx = if3.scan_idx;
                end
                if (if3.anodes != 3'b111) begin
                    case (if3.scan_idx)
                        2'd0:    exp_an = 3'b110;
                        2'd1:    exp_an = 3'b101;
                        2'd2:    exp_an = 3'b011;
                        default: exp_an = 3'b111;
                    endcase
                    chk("anode3_select", 32'(if3.anodes), 32'(exp_an));
                end
            end
        end
    end

    // Directed stimulus; expectations are queued as each step is issued.
    initial begin
        rst = 1'b1;
        if4.digits_in = 16'h0000; if4.dp_in = 4'h0; if4.digit_en = 4'h0; if4.blink_en = 4'h0;
        if4.brightness = 4'd15; if4.load = 1'b0;
        if3.digits_in = 12'h000; if3.dp_in = 3'h0; if3.digit_en = 3'h0; if3.blink_en = 3'h0;
        if3.brightness = 4'd15; if3.load = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_anodes", 32'(if4.anodes), 32'h0000000F);
        chk("reset_cathodes", 32'(if4.cathodes), 32'h000000FF);
        chk("reset_scan_idx", 32'(if4.scan_idx), 32'h00000000);
        chk("reset_frame_tick", 32'(if4.frame_tick), 32'h00000000);
        chk("reset_anodes3", 32'(if3.anodes), 32'h00000007);
        rst = 1'b0;
        mon3_en = 1'b1;
        for (int i = 0; i < 3; i++) exp3_q.push_back(96);

        // Frame 0 dark; 12AF loaded now appears from frame 1.
        push_dark_frame(1);
        push(2'd0, 4'hE, 8'h71, 8'd28);
        push(2'd1, 4'hD, 8'h11, 8'd28);
        push(2'd2, 4'hB, 8'h25, 8'd28);
        push(2'd3, 4'h7, 8'h9F, 8'd28);
        if3.digits_in = 12'h210; if3.digit_en = 3'b111;
        if3.load = 1'b1;
        load4(16'h12AF, 4'h0, 4'hF, 4'h0);
        if3.load = 1'b0;

        // Mid-frame load of zeros must not tear frame 1.
        wait_frame();
        repeat (40) @(posedge clk);
        #1;
        load4(16'h0000, 4'h0, 4'hF, 4'h0);
        for (int i = 0; i < 4; i++) push(2'(i), ~(4'b0001 << i), 8'h03, 8'd28);

        wait_frame();
        for (int i = 0; i < 4; i++) push(2'(i), ~(4'b0001 << i), 8'h03, 8'd6);
        push_dark_frame(0);

        wait_frame();
        if4.brightness = 4'd4;

        // Brightness 0 frame while loading the blink/blank/dp pattern.
        wait_frame();
        if4.brightness = 4'd0;
        load4(16'hE8DB, 4'b0010, 4'b1011, 4'b0001);
        for (int f = 5; f <= 8; f++) begin
            if (f == 6 || f == 7) push(2'd0, 4'hF, 8'hFF, 8'd0);
            else                  push(2'd0, 4'hE, 8'hC1, 8'd28);
            push(2'd1, 4'hD, 8'h84, 8'd28);
            push(2'd2, 4'hF, 8'hFF, 8'd0);
            push(2'd3, 4'h7, 8'h61, 8'd28);
        end

        wait_frame();
        if4.brightness = 4'd15;
        repeat (4) wait_frame();

        // Frame 9: load then reset mid-frame; the pending load must be dropped.
        mon_en = 1'b0;
        mon3_en = 1'b0;
        load4(16'h0000, 4'h0, 4'hF, 4'h0);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_anodes", 32'(if4.anodes), 32'h0000000F);
        chk("midreset_cathodes", 32'(if4.cathodes), 32'h000000FF);
        chk("midreset_scan_idx", 32'(if4.scan_idx), 32'h00000000);
        push_dark_frame(0);
        push_dark_frame(0);
        mon_en = 1'b1;
        rst = 1'b0;
        wait_frame();
        wait_frame();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h00000000);
        chk("frame3_drained", 32'(exp3_q.size()), 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
